// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, latency counter width
// and the reasons a request can be refused.
package dmem_pkg;

    localparam int LATENCY_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE  = 2'd0,
        FAULT_BOTH  = 2'd1,
        FAULT_ALIGN = 2'd2,
        FAULT_RANGE = 2'd3
    } fault_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Hart data-memory port: request side driven by the hart (master), response side
// driven by the memory responder (slave).
interface dmem_responder_if;

    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
    logic        fault;

    modport master (
        output addr, ren, wen, wdata, mask,
        input  ready, valid, rdata, fault
    );

    modport slave (
        input  addr, ren, wen, wdata, mask,
        output ready, valid, rdata, fault
    );

endinterface

// File: rtl/dmem_sram.sv
// Word-wide backing store with per-byte write enables and a registered read port.
// Contents are deliberately never reset.
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [3:0]    wr_en,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_reg;

    // Read returns the pre-write word; the responder never uses read data from a write.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_reg <= mem[idx];
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time from the hart, touches the
// SRAM at the acceptance edge, and returns a single-cycle response after LATENCY cycles.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam int                   AW       = $clog2(DEPTH_WORDS);
    localparam logic [LATENCY_W-1:0] CNT_INIT = LATENCY_W'(LATENCY - 1);

    state_t               state_reg, state_next;
    logic [LATENCY_W-1:0] cnt_reg, cnt_next;
    fault_t               cause_reg, cause_next;
    logic                 is_read_reg;
    logic [3:0]           mask_reg;

    logic [29:0] word_off;
    logic        accept;
    logic [3:0]  byte_we;
    logic [31:0] sram_q;
    logic [31:0] lane_bits;

    // BASE_ADDR is word aligned, so subtracting word addresses equals (addr-BASE)>>2 exactly.
    assign word_off = bus.addr[31:2] - BASE_ADDR[31:2];

    always_comb begin
        cause_next = FAULT_NONE;
        if (bus.ren && bus.wen) begin
            cause_next = FAULT_BOTH;
        end else if (bus.addr[1:0] != 2'b00) begin
            cause_next = FAULT_ALIGN;
        end else if (word_off >= 30'(DEPTH_WORDS)) begin
            cause_next = FAULT_RANGE;
        end
    end

    assign accept  = (state_reg == ST_IDLE) && (bus.ren || bus.wen);
    assign byte_we = (accept && bus.wen && cause_next == FAULT_NONE) ? bus.mask : 4'b0000;

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .rd_en (accept),
        .wr_en (byte_we),
        .idx   (word_off[AW-1:0]),
        .wdata (bus.wdata),
        .rdata (sram_q)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_BUSY;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            cause_reg   <= FAULT_NONE;
            is_read_reg <= 1'b0;
            mask_reg    <= 4'b0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                cause_reg   <= cause_next;
                is_read_reg <= bus.ren;
                mask_reg    <= bus.mask;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bits[8*gi +: 8] = {8{mask_reg[gi]}};
        end
    endgenerate

    // Disabled lanes, writes and faults all return zero data so the bus is deterministic.
    assign bus.ready = (state_reg == ST_IDLE);
    assign bus.valid = (state_reg == ST_RESP);
    assign bus.fault = bus.valid && (cause_reg != FAULT_NONE);
    assign bus.rdata = (bus.valid && is_read_reg && cause_reg == FAULT_NONE)
                     ? (sram_q & lane_bits) : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: a driver applies requests and
// pushes expected responses; a monitor pops and compares on every response pulse.
module tb_dmem_responder;

    localparam int          DEPTH = 64;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          cyc        = 0;
    int          n_pulses   = 0;
    int          n_expected = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference behaviour at the acceptance edge: update the model, queue the response.
    task automatic model_accept(input logic [31:0] addr, input logic ren, input logic wen,
                                input logic [31:0] wdata, input logic [3:0] mask);
        logic [31:0] off;
        logic [31:0] rd;
        logic [31:0] lane;
        logic        flt;
        int          idx;
        exp_t        e;
        off = addr - BASE;
        flt = (ren && wen) || (addr % 4 != 0) || (off / 4 >= DEPTH);
        idx = int'(off / 4);
        rd  = 32'h0;
        if (!flt) begin
            for (int b = 0; b < 4; b++) begin
                lane = 32'hFF << (8 * b);
                if (mask[b] && wen) mem_m[idx] = (mem_m[idx] & ~lane) | (wdata & lane);
                if (mask[b] && ren) rd = rd | (mem_m[idx] & lane);
            end
        end
        e.rdata = rd;
        e.fault = flt;
        e.due   = cyc + 1 + LAT;
        exp_q.push_back(e);
        n_expected++;
        $display("req  addr=%h ren=%0d wen=%0d wdata=%h mask=%b -> exp rdata=%h fault=%0d",
                 addr, ren, wen, wdata, mask, rd, flt);
    endtask

    // Call right after a falling edge; holds the request until n_acc acceptances.
    task automatic issue(input logic [31:0] addr, input logic ren, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] mask, input int n_acc);
        int accepted = 0;
        int low_run  = 0;
        int guard    = 0;
        bus.addr  = addr;
        bus.ren   = ren;
        bus.wen   = wen;
        bus.wdata = wdata;
        bus.mask  = mask;
        while (accepted < n_acc && guard < 100) begin
            if (bus.ready === 1'b1) begin
                if (accepted > 0) check("ready_gap", low_run, LAT + 1);
                model_accept(addr, ren, wen, wdata, mask);
                accepted++;
                low_run = 0;
            end else begin
                low_run++;
            end
            @(negedge clk);
            guard++;
        end
        if (accepted < n_acc) check("accept_timeout", accepted, n_acc);
        bus.ren = 1'b0;
        bus.wen = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 30) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: compare every response pulse with the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.valid === 1'b1) begin
                    n_pulses++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", bus.rdata, e.rdata);
                        check("fault", {31'b0, bus.fault}, {31'b0, e.fault});
                        check("latency", cyc, e.due);
                        $display("resp rdata=%h fault=%0d cycle=%0d", bus.rdata, bus.fault, cyc);
                    end
                end else begin
                    check("idle_rdata", bus.rdata, 32'h0);
                    check("idle_fault", {31'b0, bus.fault}, 32'h0);
                    if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                        e = exp_q.pop_front();
                        check("missing_valid", 0, 1);
                    end
                end
            end
        end
    end

    initial begin
        int          p0;
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;

        rst       = 1'b1;
        bus.addr  = 32'h0;
        bus.ren   = 1'b0;
        bus.wen   = 1'b0;
        bus.wdata = 32'h0;
        bus.mask  = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, bus.ready}, 32'h1);
        check("reset_valid", {31'b0, bus.valid}, 32'h0);
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_fault", {31'b0, bus.fault}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) issue(BASE + 32'(i * 4), 1'b0, 1'b1, $urandom(), 4'hF, 1);
        drain();

        issue(32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111, 1);
        issue(32'h10, 1'b1, 1'b0, 32'h0, 4'b1111, 1);
        issue(32'h10, 1'b0, 1'b1, 32'h55000000, 4'b1000, 1);
        issue(32'h10, 1'b1, 1'b0, 32'h0, 4'b1111, 1);
        issue(32'h10, 1'b1, 1'b0, 32'h0, 4'b0011, 1);
        issue(32'h10, 1'b1, 1'b0, 32'h0, 4'b0000, 1);
        issue(32'h20, 1'b1, 1'b1, 32'hA5A5A5A5, 4'b1111, 1);
        issue(32'h20, 1'b1, 1'b0, 32'h0, 4'b1111, 1);
        issue(32'h12, 1'b1, 1'b0, 32'h0, 4'b1111, 1);
        issue(BASE + DEPTH * 4, 1'b1, 1'b0, 32'h0, 4'b1111, 1);
        issue(BASE - 32'd4, 1'b1, 1'b0, 32'h0, 4'b1111, 1);
        drain();

        p0 = n_pulses;
        issue(32'h10, 1'b1, 1'b0, 32'h0, 4'b1111, 3);
        drain();
        check("burst_pulses", n_pulses - p0, 3);

        issue(32'h30, 1'b0, 1'b1, 32'h12345678, 4'b1111, 1);
        rst = 1'b1;
        #1;
        check("midreset_ready", {31'b0, bus.ready}, 32'h1);
        check("midreset_valid", {31'b0, bus.valid}, 32'h0);
        exp_q.delete();
        n_expected--;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(32'h30, 1'b1, 1'b0, 32'h0, 4'b1111, 1);
        drain();

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 19);
            a    = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            d    = $urandom();
            m    = 4'($urandom_range(0, 15));
            case (kind)
                0:       issue(a, 1'b1, 1'b1, d, m, 1);
                1:       issue(a + 32'($urandom_range(1, 3)), 1'b1, 1'b0, d, m, 1);
                2:       issue(($urandom() | 32'h100) & ~32'h3, 1'b1, 1'b0, d, m, 1);
                3, 4, 5, 6, 7, 8: issue(a, 1'b0, 1'b1, d, m, 1);
                default: issue(a, 1'b1, 1'b0, d, m, 1);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        check("total_pulses", n_pulses, n_expected);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
